pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It is the multi-bit, registered successor of the single-bit full adder used across the datapath. The WIDTH-bit carry chain is split into STAGES registered segments, each a ripple of full-adder cells. A valid/ready handshake with full backpressure lets it sit directly between streaming producers and consumers at one result per cycle.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_chunk.sv | 27 ++
 rtl/pipelined_adder.sv | 122 ++++++++++++
 tb/tb_pipelined_adder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: segment sizing, configuration check
// and the per-stage control record.
package adder_pkg;

   function automatic int chunk_w(input int width, input int stages);
      return (stages > 0) ? width / stages : width;
   endfunction

   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (width % stages == 0);
   endfunction

   // Occupancy plus the carry handed to the next segment (the last stage's carry is cout).
   typedef struct packed {
      logic vld;
      logic carry;
   } stage_ctl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple of full-adder cells; also exposes the carry into the
// top bit so the caller can derive signed overflow.
module adder_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         c_msb_in
);

   always_comb begin
      logic v_c;
      v_c      = cin;
      sum      = '0;
      c_msb_in = cin;
      for (int i = 0; i < W; i++) begin
         c_msb_in = v_c;
         sum[i]   = a[i] ^ b[i] ^ v_c;
         v_c      = (a[i] & b[i]) | (v_c & (a[i] ^ b[i]));
      end
      cout = v_c;
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered ripple
// segments with a valid/ready handshake and full backpressure.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = chunk_w(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   logic [STAGES-1:0] w_vld;
   logic [STAGES-1:0] w_load;

   // A stage loads when empty or when its occupant moves on this cycle; this
   // chain is the combinational out_ready -> in_ready path.
   always_comb begin
      logic v_take;
      v_take = out_ready;
      w_load = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         v_take    = !w_vld[k] || v_take;
         w_load[k] = v_take;
      end
   end

   assign in_ready = w_load[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO   = k * CHUNK;
      localparam int DONE = LO + CHUNK;

      logic [WIDTH-LO-1:0] w_a_in;
      logic [WIDTH-LO-1:0] w_b_in;
      logic                w_c_in;
      logic                w_vld_in;
      logic [CHUNK-1:0]    w_sum;
      logic                w_cout;
      logic                w_cmsb;
      logic [DONE-1:0]     r_sum;
      stage_ctl_t          r_ctl;

      adder_chunk #(.W(CHUNK)) u_chunk (
         .a        (w_a_in[CHUNK-1:0]),
         .b        (w_b_in[CHUNK-1:0]),
         .cin      (w_c_in),
         .sum      (w_sum),
         .cout     (w_cout),
         .c_msb_in (w_cmsb)
      );

      always_ff @(posedge clk) begin
         if (!rst_n)
            r_ctl.vld <= 1'b0;
         else if (w_load[k])
            r_ctl.vld <= w_vld_in;
         if (w_load[k])
            r_ctl.carry <= w_cout;
      end

      assign w_vld[k] = r_ctl.vld;

      // B is inverted once at entry so every segment is a plain adder.
      if (k == 0) begin : g_in
         assign w_a_in   = a;
         assign w_b_in   = b ^ {WIDTH{sub}};
         assign w_c_in   = cin;
         assign w_vld_in = in_valid;
         always_ff @(posedge clk)
            if (w_load[k]) r_sum <= w_sum;
      end else begin : g_chain
         assign w_a_in   = g_stage[k-1].g_mid.r_a;
         assign w_b_in   = g_stage[k-1].g_mid.r_b;
         assign w_c_in   = g_stage[k-1].r_ctl.carry;
         assign w_vld_in = w_vld[k-1];
         always_ff @(posedge clk)
            if (w_load[k]) r_sum <= {w_sum, g_stage[k-1].r_sum};
      end

      if (k == STAGES - 1) begin : g_last
         logic r_ovf;
         always_ff @(posedge clk)
            if (w_load[k]) r_ovf <= w_cmsb ^ w_cout;
      end else begin : g_mid
         logic                  w_unused_cmsb;
         logic [WIDTH-DONE-1:0] r_a;
         logic [WIDTH-DONE-1:0] r_b;
         assign w_unused_cmsb = w_cmsb;
         always_ff @(posedge clk) begin
            if (w_load[k]) begin
               r_a <= w_a_in[WIDTH-LO-1:CHUNK];
               r_b <= w_b_in[WIDTH-LO-1:CHUNK];
            end
         end
      end
   end

   // Result registers carry no reset, so outputs are forced to zero while empty.
   assign out_valid = w_vld[STAGES-1];
   assign sum       = out_valid ? g_stage[STAGES-1].r_sum : '0;
   assign cout      = out_valid && g_stage[STAGES-1].r_ctl.carry;
   assign ovf       = out_valid && g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: an 8-bit/2-stage instance for directed
// corner, stall and reset cases and a 32-bit/4-stage instance for random traffic.
module tb_pipelined_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic        iv32, ir32, ov32, or32, cin32, sub32, cout32, ovf32;
   logic [31:0] a32, b32, sum32;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
      .cout(cout8), .ovf(ovf8));

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
      .cout(cout32), .ovf(ovf32));

   typedef struct packed {
      logic        ovf;
      logic        cout;
      logic [31:0] sum;
   } res_t;

   // Reference: unsigned sum for {cout,sum}, signed range test for overflow.
   function automatic res_t ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
      logic [63:0] mask, av, bv, s;
      longint      sa, sb, sr, lim;
      res_t        r;
      mask  = (64'd1 << w) - 64'd1;
      av    = {32'd0, a} & mask;
      bv    = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
      s     = av + bv + {63'd0, cin};
      r.sum = s[31:0] & mask[31:0];
      r.cout = s[w];
      lim   = longint'(1) << (w - 1);
      sa    = av[w-1] ? longint'(av) - (lim << 1) : longint'(av);
      sb    = bv[w-1] ? longint'(bv) - (lim << 1) : longint'(bv);
      sr    = sa + sb + longint'(cin);
      r.ovf = (sr >= lim) || (sr < -lim);
      return r;
   endfunction

   task automatic rand8();
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL reset_out_valid8 got %b exp 0", ov8); end
      checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum8 got %h exp 00", sum8); end
      checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout8 got %b exp 0", cout8); end
      checks++; if (ovf8 !== 1'b0)  begin errors++; $display("FAIL reset_ovf8 got %b exp 0", ovf8); end
      checks++; if (ir8 !== 1'b1)   begin errors++; $display("FAIL reset_in_ready8 got %b exp 1", ir8); end
      checks++; if (ov32 !== 1'b0)  begin errors++; $display("FAIL reset_out_valid32 got %b exp 0", ov32); end
      checks++; if (ir32 !== 1'b1)  begin errors++; $display("FAIL reset_in_ready32 got %b exp 1", ir32); end
   endtask

   // 0xFF + 0x01: result must appear exactly 2 cycles after the accepting cycle.
   task automatic test_latency8();
      @(posedge clk); #1;
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
      @(negedge clk);
      checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL lat8_in_ready got %b exp 1", ir8); end
      for (int t = 0; t < 2; t++) begin
         checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL lat8_early cycle %0d got %b exp 0", t, ov8); end
         @(posedge clk); #1 iv8 = 1'b0;
         @(negedge clk);
      end
      checks++; if (ov8 !== 1'b1)   begin errors++; $display("FAIL lat8_valid got %b exp 1", ov8); end
      checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL lat8_sum got %h exp 00", sum8); end
      checks++; if (cout8 !== 1'b1) begin errors++; $display("FAIL lat8_cout got %b exp 1", cout8); end
      checks++; if (ovf8 !== 1'b0)  begin errors++; $display("FAIL lat8_ovf got %b exp 0", ovf8); end
   endtask

   task automatic test_latency32();
      res_t exp;
      @(posedge clk); #1;
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
      iv32 = 1'b1; or32 = 1'b1;
      exp = ref_op(32, a32, b32, cin32, sub32);
      @(negedge clk);
      checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL lat32_in_ready got %b exp 1", ir32); end
      for (int t = 0; t < 4; t++) begin
         checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL lat32_early cycle %0d got %b exp 0", t, ov32); end
         @(posedge clk); #1 iv32 = 1'b0;
         @(negedge clk);
      end
      checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL lat32_valid got %b exp 1", ov32); end
      checks++;
      if ({ovf32, cout32, sum32} !== exp) begin
         errors++; $display("FAIL lat32_result got %h exp %h", {ovf32, cout32, sum32}, exp);
      end
   endtask

   task automatic test_corners();
      logic [7:0] ta[4] = '{8'hFF, 8'h80, 8'h7F, 8'h05};
      logic [7:0] tb[4] = '{8'h01, 8'h01, 8'h01, 8'h03};
      logic       tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic       ts[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [9:0] te[4] = '{{1'b0, 1'b1, 8'h00}, {1'b1, 1'b1, 8'h7F},
                            {1'b1, 1'b0, 8'h80}, {1'b0, 1'b1, 8'h01}};
      logic       got;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         a8 = ta[i]; b8 = tb[i]; cin8 = tc[i]; sub8 = ts[i]; iv8 = 1'b1; or8 = 1'b1;
         @(posedge clk); #1 iv8 = 1'b0;
         got = 1'b0;
         for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (ov8) begin got = 1'b1; break; end
         end
         checks++;
         if (!got) begin
            errors++; $display("FAIL corner%0d_timeout got no out_valid exp 1", i);
         end else if ({ovf8, cout8, sum8} !== te[i]) begin
            errors++; $display("FAIL corner%0d_result got ovf,cout,sum=%h exp %h", i, {ovf8, cout8, sum8}, te[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t q[$];
      res_t exp;
      int   sent = 0, rcvd = 0, drops = 0, first = -1, last = -1;
      logic acc;
      @(posedge clk); #1;
      or8 = 1'b1; iv8 = 1'b1; rand8();
      for (int cyc = 0; cyc < 40 && rcvd < 16; cyc++) begin
         @(negedge clk);
         if (iv8 && !ir8) drops++;
         if (ov8 && or8) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_extra got sum %h exp none", sum8);
            end else begin
               exp = q.pop_front();
               if ({ovf8, cout8, sum8} !== {exp.ovf, exp.cout, exp.sum[7:0]}) begin
                  errors++; $display("FAIL b2b_result%0d got %h exp %h", rcvd, {ovf8, cout8, sum8}, {exp.ovf, exp.cout, exp.sum[7:0]});
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            rcvd++;
         end
         acc = iv8 && ir8;
         if (acc) begin q.push_back(ref_op(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8)); sent++; end
         @(posedge clk); #1;
         if (acc) begin
            if (sent < 16) rand8(); else iv8 = 1'b0;
         end
      end
      checks++; if (drops != 0)  begin errors++; $display("FAIL b2b_in_ready_drops got %0d exp 0", drops); end
      checks++; if (rcvd != 16)  begin errors++; $display("FAIL b2b_count got %0d exp 16", rcvd); end
      checks++; if (last - first != 15) begin errors++; $display("FAIL b2b_rate got span %0d exp 15", last - first); end
   endtask

   task automatic test_stall();
      res_t q[$];
      res_t exp;
      int   sent = 0, rcvd = 0;
      logic acc;
      @(posedge clk); #1;
      or8 = 1'b0; iv8 = 1'b1; rand8();
      for (int cyc = 0; cyc < 30 && rcvd < 4; cyc++) begin
         @(negedge clk);
         if (cyc >= 2 && cyc <= 6) begin
            checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b exp 0", cyc, ir8); end
            checks++;
            if (ov8 !== 1'b1 || {ovf8, cout8, sum8} !== {q[0].ovf, q[0].cout, q[0].sum[7:0]}) begin
               errors++; $display("FAIL stall_hold cyc %0d got v=%b %h exp v=1 %h", cyc, ov8, {ovf8, cout8, sum8}, {q[0].ovf, q[0].cout, q[0].sum[7:0]});
            end
         end
         if (ov8 && or8) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL stall_extra got sum %h exp none", sum8);
            end else begin
               exp = q.pop_front();
               if ({ovf8, cout8, sum8} !== {exp.ovf, exp.cout, exp.sum[7:0]}) begin
                  errors++; $display("FAIL stall_drain%0d got %h exp %h", rcvd, {ovf8, cout8, sum8}, {exp.ovf, exp.cout, exp.sum[7:0]});
               end
            end
            rcvd++;
         end
         acc = iv8 && ir8;
         if (acc) begin q.push_back(ref_op(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8)); sent++; end
         @(posedge clk); #1;
         if (acc) begin
            if (sent < 4) rand8(); else iv8 = 1'b0;
         end
         or8 = (cyc >= 6);
      end
      checks++; if (rcvd != 4 || q.size() != 0) begin errors++; $display("FAIL stall_count got %0d left %0d exp 4 left 0", rcvd, q.size()); end
      @(negedge clk);
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL stall_dup got %b exp 0", ov8); end
   endtask

   task automatic test_reset_midflight();
      @(posedge clk); #1;
      or8 = 1'b1; iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; sub8 = 1'b0;
      @(posedge clk); #1;
      a8 = 8'hF0; b8 = 8'h44;
      @(posedge clk); #1;
      iv8 = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL midrst_out_valid got %b exp 0", ov8); end
      checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL midrst_sum got %h exp 00", sum8); end
      checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b exp 0", cout8); end
      checks++; if (ovf8 !== 1'b0)  begin errors++; $display("FAIL midrst_ovf got %b exp 0", ovf8); end
      checks++; if (ir8 !== 1'b1)   begin errors++; $display("FAIL midrst_in_ready got %b exp 1", ir8); end
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d got %b exp 0", t, ov8); end
      end
   endtask

   task automatic test_random32();
      res_t        q[$];
      res_t        exp;
      int          sent = 0, rcvd = 0;
      logic        acc, held = 1'b0;
      logic [33:0] held_val;
      iv32 = 1'b0;
      for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
         @(negedge clk);
         if (held) begin
            checks++;
            if (ov32 !== 1'b1 || {ovf32, cout32, sum32} !== held_val) begin
               errors++; $display("FAIL rand_hold got v=%b %h exp v=1 %h", ov32, {ovf32, cout32, sum32}, held_val);
            end
         end
         held     = ov32 && !or32;
         held_val = {ovf32, cout32, sum32};
         if (ov32 && or32) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_extra got sum %h exp none", sum32);
            end else begin
               exp = q.pop_front();
               if ({ovf32, cout32, sum32} !== exp) begin
                  errors++; $display("FAIL rand_result%0d got %h exp %h", rcvd, {ovf32, cout32, sum32}, exp);
               end
            end
            rcvd++;
         end
         acc = iv32 && ir32;
         if (acc) begin q.push_back(ref_op(32, a32, b32, cin32, sub32)); sent++; end
         @(posedge clk); #1;
         if (acc || !iv32) begin
            if (sent < 1000) begin
               iv32 = 1'($urandom);
               a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
            end else begin
               iv32 = 1'b0;
            end
         end
         or32 = 1'($urandom);
      end
      checks++; if (rcvd != 1000)    begin errors++; $display("FAIL rand_count got %0d exp 1000", rcvd); end
      checks++; if (q.size() != 0)   begin errors++; $display("FAIL rand_leftover got %0d exp 0", q.size()); end
   endtask

   initial begin
      rst_n = 1'b0;
      iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
      test_reset();
      test_latency8();
      test_latency32();
      test_corners();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_random32();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
